// File: rtl/punc_mem_arbiter_pkg.sv
// punc_mem_arbiter_pkg
//   Shared definitions for the PUnC memory arbiter: FSM state encodings,
//   access owner IDs, latency counter width and a width helper for the
//   debug starvation counter.
package punc_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_CPU = 1'b0,
    ARB_OWN_DBG = 1'b1
  } arb_owner_t;

  // Enough for MEM_LAT up to 7 (counter holds MEM_LAT-1 .. 0).
  localparam int unsigned LAT_CNT_W = 3;

  function automatic int unsigned starve_w(input int unsigned smax);
    return (smax < 1) ? 1 : $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/punc_arb_pick.sv
// punc_arb_pick
//   Combinational winner select for the PUnC memory arbiter plus the
//   register that shapes fairness (debug starvation counter, or the
//   last-granted owner in round-robin builds).
//   Config macro: PUNC_ARB_RR_EN (round-robin on simultaneous requests).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   arb_en            arbiter may grant this cycle (IDLE and not in reset)
//   cpu_req, dbg_req  raw requests
//   cpu_win, dbg_win  one-hot grant for this cycle (already qualified by arb_en)
module punc_arb_pick
  import punc_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_win,
  output logic dbg_win
);

  logic dbg_first;

`ifdef PUNC_ARB_RR_EN
  arb_owner_t last_own;

  // Reset value makes the CPU win the first contested arbitration.
  always_ff @(posedge clk) begin
    if (rst)          last_own <= ARB_OWN_DBG;
    else if (cpu_win) last_own <= ARB_OWN_CPU;
    else if (dbg_win) last_own <= ARB_OWN_DBG;
  end

  always_comb dbg_first = (last_own == ARB_OWN_CPU);
`else
  localparam int unsigned SW = starve_w(STARVE_MAX);
  logic [SW-1:0] starve_cnt;

  // Counts every cycle debug waits, including cycles the arbiter is busy.
  always_ff @(posedge clk) begin
    if (rst || !dbg_req || dbg_win)           starve_cnt <= '0;
    else if (starve_cnt != SW'(STARVE_MAX))   starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb dbg_first = (STARVE_MAX > 0) && (starve_cnt == SW'(STARVE_MAX));
`endif

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (arb_en) begin
      if (cpu_req && dbg_req) begin
        if (dbg_first) dbg_win = 1'b1;
        else           cpu_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter
//   Shares the single-port PUnC memory between the CPU control path and the
//   debug/loader port. One access in flight; IDLE -> ISSUE -> WAIT -> IDLE,
//   WAIT lasting MEM_LAT cycles (skipped when MEM_LAT = 0).
//   Config macro: PUNC_ARB_RR_EN selects round-robin instead of CPU
//   priority with a STARVE_MAX bound for debug.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata CPU grant pulse, completion pulse, read data
//   dbg_*                         same set for the debug/loader port
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata          memory macro interface
//   busy                          high whenever an access is in progress
module punc_mem_arbiter
  import punc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT =
    (MEM_LAT > 0) ? LAT_CNT_W'(MEM_LAT - 1) : '0;

  arb_state_t           state, state_nxt;
  arb_owner_t           owner;
  logic                 acc_we;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 arb_en;
  logic                 cpu_win, dbg_win;
  logic                 capture;

  // Grants are suppressed while rst is high so reset holds all pulses low.
  always_comb arb_en = (state == ARB_IDLE) && !rst;

  punc_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .cpu_win (cpu_win),
    .dbg_win (dbg_win)
  );

  always_comb begin
    cpu_gnt = cpu_win;
    dbg_gnt = dbg_win;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    case (state)
      ARB_IDLE: begin
        busy = 1'b0;
        if (cpu_win || dbg_win) state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_en = 1'b1;
        mem_we = acc_we;
        if (MEM_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = ARB_IDLE;
        end else begin
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (lat_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= ARB_OWN_CPU;
      acc_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_cnt    <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      // Completion pulse lands in the following (IDLE) cycle.
      cpu_rvalid <= capture && (owner == ARB_OWN_CPU);
      dbg_rvalid <= capture && (owner == ARB_OWN_DBG);

      if (cpu_win) begin
        owner     <= ARB_OWN_CPU;
        acc_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (dbg_win) begin
        owner     <= ARB_OWN_DBG;
        acc_we    <= dbg_we;
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
      end

      if (state == ARB_ISSUE)                          lat_cnt <= LAT_INIT;
      else if (state == ARB_WAIT && lat_cnt != '0)     lat_cnt <= lat_cnt - 1'b1;

      if (capture && !acc_we) begin
        if (owner == ARB_OWN_CPU) cpu_rdata <= mem_rdata;
        else                      dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule
